dcache_nway: RTL and testbench

- Parametrised L1 data cache for the pipelined CPU; sits between the EX/MEM stage register and the line-wide data memory.
- Generalises the direct-mapped dcache to WAYS-way set associativity, with true-LRU replacement, write-back/write-allocate, and an explicit whole-cache flush.
- A hit completes combinationally in the same cycle. A miss raises p1_stall_o, which halts PC, IF_ID, ID_EX, EX_MEM and MEM_WB until the access completes.

---
 rtl/dcache_nway.sv | 244 ++++++++++++++++++++++++
 tb/tb_dcache_nway.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// dcache_nway: WAYS-way set-associative L1 data cache, write-back /
// write-allocate, true-LRU replacement, whole-cache flush.
module dcache_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  localparam int OB    = $clog2(LINE_W / 8);
  localparam int IB    = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OB - IB;
  localparam int WORDS = LINE_W / 32;
  localparam int WS_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAY_B = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int AW    = (WAYS > 1) ? WAY_B : 1;
  localparam int ENT   = SETS * WAYS;
  localparam int EIW   = IB + WAY_B;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_REFILL, S_FILLED, S_FLUSH_SCAN, S_FLUSH_WB, S_FLUSH_DONE
  } state_t;

  // Entry index is {set, way}; with one way the way field vanishes.
  function automatic logic [EIW-1:0] ent(input logic [IB-1:0] s, input logic [AW-1:0] w);
    ent = EIW'({s, w} >> (AW - WAY_B));
  endfunction

  state_t            r_state, w_state_next;
  logic [LINE_W-1:0] r_data [ENT];
  logic [TAG_W-1:0]  r_tag  [ENT];
  logic [AW-1:0]     r_age  [ENT];
  logic [ENT-1:0]    r_valid, r_dirty;
  logic [EIW:0]      r_scan;
  logic [31:0]       r_rdata;
  logic              r_mem_enable, r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;

  logic [IB-1:0]     w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [WS_W-1:0]   w_word;
  logic              w_req, w_hit, w_vic_found, w_ack, w_touch, w_fill, w_rd_hit;
  logic [AW-1:0]     w_hit_way, w_victim, w_touch_way;
  logic [EIW-1:0]    w_hit_e, w_vic_e, w_touch_e, w_scan_e;
  logic [IB-1:0]     w_scan_set;
  logic              w_scan_done;
  logic [LINE_W-1:0] w_hit_line;
  logic [31:0]       w_rd_word;

  assign w_index     = p1_addr_i[OB +: IB];
  assign w_tag       = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_word      = WS_W'((p1_addr_i >> 2) & ADDR_W'(WORDS - 1));
  assign w_req       = p1_MemRead_i | p1_MemWrite_i;
  assign w_ack       = mem_ack_i & r_mem_enable;
  assign w_hit_e     = ent(w_index, w_hit_way);
  assign w_vic_e     = ent(w_index, w_victim);
  assign w_hit_line  = r_data[w_hit_e];
  assign w_rd_word   = w_hit_line[{w_word, 5'b0} +: 32];
  assign w_scan_e    = r_scan[EIW-1:0];
  assign w_scan_done = r_scan[EIW];
  assign w_scan_set  = IB'(w_scan_e >> WAY_B);

  assign w_touch     = (r_state == S_IDLE) && w_req && w_hit;
  assign w_fill      = (r_state == S_REFILL) && w_ack;
  assign w_touch_way = w_fill ? w_victim : w_hit_way;
  assign w_touch_e   = ent(w_index, w_touch_way);
  assign w_rd_hit    = w_touch && p1_MemRead_i && !p1_MemWrite_i;

  assign p1_stall_o   = (r_state != S_IDLE) || (w_req && !w_hit);
  assign p1_data_o    = w_rd_hit ? w_rd_word : r_rdata;
  assign flush_done_o = (r_state == S_FLUSH_DONE);
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  // Tag compare across the ways of the addressed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[ent(w_index, AW'(w))] && (r_tag[ent(w_index, AW'(w))] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AW'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    w_victim    = '0;
    w_vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_vic_found && !r_valid[ent(w_index, AW'(w))]) begin
        w_victim    = AW'(w);
        w_vic_found = 1'b1;
      end
    end
    if (!w_vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[ent(w_index, AW'(w))] == AW'(WAYS - 1)) w_victim = AW'(w);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (flush_i) w_state_next = S_FLUSH_SCAN;
        else if (w_req && !w_hit)
          w_state_next = (r_valid[w_vic_e] && r_dirty[w_vic_e]) ? S_WB : S_REFILL;
      end
      S_WB:         if (w_ack) w_state_next = S_REFILL;
      S_REFILL:     if (w_ack) w_state_next = S_FILLED;
      S_FILLED:     w_state_next = S_IDLE;
      S_FLUSH_SCAN: begin
        if (w_scan_done) w_state_next = S_FLUSH_DONE;
        else if (r_dirty[w_scan_e]) w_state_next = S_FLUSH_WB;
      end
      S_FLUSH_WB:   if (w_ack) w_state_next = S_FLUSH_SCAN;
      S_FLUSH_DONE: w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Cache arrays, LRU ages, flush pointer and the registered memory request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= '0;
      r_dirty      <= '0;
      r_scan       <= '0;
      r_rdata      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      for (int e = 0; e < ENT; e++) r_age[EIW'(e)] <= AW'(e % WAYS);
    end else begin
      if (w_touch || w_fill) begin
        for (int w = 0; w < WAYS; w++) begin
          if (r_age[ent(w_index, AW'(w))] < r_age[w_touch_e])
            r_age[ent(w_index, AW'(w))] <= r_age[ent(w_index, AW'(w))] + 1'b1;
        end
        r_age[w_touch_e] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_touch) begin
            if (p1_MemWrite_i) begin
              r_data[w_hit_e][{w_word, 5'b0} +: 32] <= p1_data_i;
              r_dirty[w_hit_e] <= 1'b1;
            end else begin
              r_rdata <= w_rd_word;
            end
          end
          if (flush_i) begin
            r_scan <= '0;
          end else if (w_req && !w_hit) begin
            r_mem_enable <= 1'b1;
            if (r_valid[w_vic_e] && r_dirty[w_vic_e]) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_vic_e], w_index, {OB{1'b0}}};
              r_mem_data  <= r_data[w_vic_e];
            end else begin
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_tag, w_index, {OB{1'b0}}};
            end
          end
        end
        S_WB: begin
          if (w_ack) begin
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
          end
        end
        S_REFILL: begin
          // Arriving from a write-back the request is re-issued here.
          if (!r_mem_enable) begin
            r_mem_enable <= 1'b1;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= {w_tag, w_index, {OB{1'b0}}};
          end else if (w_ack) begin
            r_mem_enable     <= 1'b0;
            r_data[w_vic_e]  <= mem_data_i;
            r_tag[w_vic_e]   <= w_tag;
            r_valid[w_vic_e] <= 1'b1;
            r_dirty[w_vic_e] <= 1'b0;
          end
        end
        S_FLUSH_SCAN: begin
          if (!w_scan_done) begin
            if (r_dirty[w_scan_e]) begin
              r_mem_enable <= 1'b1;
              r_mem_write  <= 1'b1;
              r_mem_addr   <= {r_tag[w_scan_e], w_scan_set, {OB{1'b0}}};
              r_mem_data   <= r_data[w_scan_e];
            end else begin
              r_valid[w_scan_e] <= 1'b0;
              r_scan            <= r_scan + 1'b1;
            end
          end
        end
        S_FLUSH_WB: begin
          if (w_ack) begin
            r_mem_enable      <= 1'b0;
            r_mem_write       <= 1'b0;
            r_valid[w_scan_e] <= 1'b0;
            r_dirty[w_scan_e] <= 1'b0;
            r_scan            <= r_scan + 1'b1;
          end
        end
        S_FLUSH_DONE: begin
          for (int e = 0; e < ENT; e++) r_age[EIW'(e)] <= AW'(e % WAYS);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway with the default parameters.
module tb_dcache_nway;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         flush_i = 1'b0;
  logic         flush_done_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  int n_checks = 0;
  int n_errors = 0;

  dcache_nway dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic        exp_stall;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Wait for a memory request, check it, hold ack off for lat cycles, then ack.
  task automatic serve(input string nm, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [255:0] line, input int lat, output logic [255:0] wb);
    int n;
    n = 0;
    wb = '0;
    while (!mem_enable_o && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_req"}, mem_enable_o, 1'b1);
    if (mem_enable_o) begin
      check({nm, "_write"}, mem_write_o, exp_wr);
      check({nm, "_addr"}, mem_addr_o, exp_addr);
      wb = mem_data_o;
      for (int i = 0; i < lat; i++) tick();
      mem_data_i = line;
      mem_ack_i  = 1'b1;
      tick();
      mem_ack_i  = 1'b0;
    end
  endtask

  // Read miss with optional write-back, then the replayed read must hit.
  task automatic access_miss(input string nm, input logic [31:0] addr, input logic exp_wb,
                             input logic [31:0] wb_addr, input logic [255:0] line,
                             output logic [255:0] wb_line);
    logic [255:0] dummy;
    logic [2:0]   wsel;
    p1_addr_i = addr; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    #1;
    check({nm, "_miss_stall"}, p1_stall_o, 1'b1);
    wb_line = '0;
    if (exp_wb) serve({nm, "_wb"}, 1'b1, wb_addr, '0, 2, wb_line);
    serve({nm, "_refill"}, 1'b0, addr, line, 3, dummy);
    check({nm, "_filled_stall"}, p1_stall_o, 1'b1);
    check({nm, "_enable_drop"}, mem_enable_o, 1'b0);
    tick();
    wsel = addr[4:2];
    check({nm, "_hit_stall"}, p1_stall_o, 1'b0);
    check({nm, "_hit_data"}, p1_data_o, line[wsel*32 +: 32]);
  endtask

  task automatic rd_stall(input string nm, input logic [31:0] addr, input logic exp);
    p1_addr_i = addr; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    #1;
    check(nm, p1_stall_o, exp);
  endtask

  task automatic wr_hit(input string nm, input logic [31:0] addr, input logic [31:0] d);
    p1_addr_i = addr; p1_data_i = d; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b1;
    #1;
    check(nm, p1_stall_o, 1'b0);
    tick();
    p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    vec_t         vecs[6];
    logic [255:0] line1, wb;
    int           n, extra;

    vecs[0] = '{"rd_48",   32'h48, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{"rd_40",   32'h40, 32'h0,        1'b1, 1'b0, 1'b0, 32'h10000000};
    vecs[2] = '{"wr_44",   32'h44, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h10000000};
    vecs[3] = '{"rd_44",   32'h44, 32'h0,        1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[4] = '{"rd_5c",   32'h5C, 32'h0,        1'b1, 1'b0, 1'b0, 32'h10000007};
    vecs[5] = '{"idle",    32'h5C, 32'h0,        1'b0, 1'b0, 1'b0, 32'h10000007};

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_mdata", mem_data_o[63:0], 64'h0);
    check("rst_flush_done", flush_done_o, 1'b0);
    check("rst_data", p1_data_o, 32'h0);
    check("rst_stall", p1_stall_o, 1'b0);

    // First miss: ack five cycles after the request appears
    line1 = make_line(32'h10000000);
    line1[95:64] = 32'hDEADBEEF;
    rd_stall("m1_stall", 32'h40, 1'b1);
    serve("m1", 1'b0, 32'h40, line1, 4, wb);
    check("m1_filled_stall", p1_stall_o, 1'b1);
    check("m1_enable_drop", mem_enable_o, 1'b0);
    tick();
    check("m1_replay_stall", p1_stall_o, 1'b0);

    // Hit traffic on the resident line
    for (int i = 0; i < 6; i++) begin
      p1_addr_i = vecs[i].addr; p1_data_i = vecs[i].wdata;
      p1_MemRead_i = vecs[i].rd; p1_MemWrite_i = vecs[i].wr;
      #2;
      check({vecs[i].name, "_stall"}, p1_stall_o, vecs[i].exp_stall);
      check({vecs[i].name, "_data"}, p1_data_o, vecs[i].exp_data);
      @(posedge clk_i); #1;
    end
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;

    // Second line of set 2 fills the invalid way; 0x40 becomes LRU
    access_miss("m240", 32'h240, 1'b0, 32'h0, make_line(32'h20000000), wb);
    // Dirty LRU victim 0x40 is written back before 0x440 is fetched
    access_miss("m440", 32'h440, 1'b1, 32'h40, make_line(32'h30000000), wb);
    check("m440_wb_word1", wb[63:32], 32'h12345678);
    rd_stall("keep_240", 32'h240, 1'b0);
    check("keep_240_data", p1_data_o, 32'h20000000);
    tick();

    // Touch 0x240 then 0x440: 0x240 is now LRU and clean
    rd_stall("touch_240", 32'h240, 1'b0); tick();
    rd_stall("touch_440", 32'h440, 1'b0); tick();
    access_miss("m40", 32'h40, 1'b0, 32'h0, make_line(32'h40000000), wb);
    rd_stall("keep_440", 32'h440, 1'b0);
    check("keep_440_data", p1_data_o, 32'h30000000);
    tick();
    rd_stall("gone_240", 32'h240, 1'b1);
    p1_MemRead_i = 1'b0;
    tick();

    // Flush with two dirty lines in set 2 (way0 = 0x440, way1 = 0x40)
    wr_hit("wr_44_dirty", 32'h44, 32'hAAAA0001);
    wr_hit("wr_440_dirty", 32'h440, 32'hBBBB0002);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    serve("fl_wb0", 1'b1, 32'h440, '0, 1, wb);
    check("fl_wb0_word0", wb[31:0], 32'hBBBB0002);
    serve("fl_wb1", 1'b1, 32'h40, '0, 1, wb);
    check("fl_wb1_word1", wb[63:32], 32'hAAAA0001);
    n = 0; extra = 0;
    while (!flush_done_o && n < 200) begin
      if (mem_enable_o) extra++;
      tick();
      n++;
    end
    check("fl_done_seen", flush_done_o, 1'b1);
    check("fl_extra_req", 64'(extra), 64'h0);
    tick();
    check("fl_done_pulse", flush_done_o, 1'b0);
    rd_stall("fl_miss_40", 32'h40, 1'b1);
    rd_stall("fl_miss_240", 32'h240, 1'b1);
    rd_stall("fl_miss_440", 32'h440, 1'b1);
    p1_MemRead_i = 1'b0;
    tick();

    // Reset during a refill abandons it
    rd_stall("rr_stall", 32'h40, 1'b1);
    tick();
    check("rr_req", mem_enable_o, 1'b1);
    rst_i = 1'b1; p1_MemRead_i = 1'b0;
    tick();
    rst_i = 1'b0;
    check("rr_enable", mem_enable_o, 1'b0);
    check("rr_stall_clear", p1_stall_o, 1'b0);
    check("rr_addr", mem_addr_o, 32'h0);
    access_miss("rr_m40", 32'h40, 1'b0, 32'h0, make_line(32'h50000000), wb);
    p1_MemRead_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
